// File: rtl/edulent_pkg.sv
// Shared types and constants for the EDULENT datapath.
package edulent_pkg;

    typedef enum logic [3:0] {
        CMD_NONE   = 4'h0,
        CMD_MA_PC  = 4'h1,
        CMD_MD_MEM = 4'h2,
        CMD_IR_MD  = 4'h3,
        CMD_MA_MD  = 4'h4,
        CMD_ACC_MD = 4'h5,
        CMD_MA_AP  = 4'h6,
        CMD_MA_SP  = 4'h7,
        CMD_MD_ACC = 4'h8,
        CMD_MEM_WR = 4'h9,
        CMD_ACC_R  = 4'hA,
        CMD_PC_MD  = 4'hB,
        CMD_A_IN   = 4'hC,
        CMD_OUT_A  = 4'hD,
        CMD_PC_AP  = 4'hE,
        CMD_MD_PC  = 4'hF
    } transfer_cmd_t;

    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_INC  = 2'b01,
        SP_DEC  = 2'b10
    } sp_op_t;

    localparam logic [7:0] OP_JZ   = 8'hA5;
    localparam logic [7:0] OP_JC   = 8'hA9;
    localparam logic [7:0] OP_CALL = 8'hC1;

    localparam logic [3:0] ALU_ADD = 4'h3;
    localparam logic [3:0] ALU_SUB = 4'h4;
    localparam logic [3:0] ALU_NOT = 4'h5;
    localparam logic [3:0] ALU_AND = 4'h6;
    localparam logic [3:0] ALU_OR  = 4'h7;
    localparam logic [3:0] ALU_XOR = 4'h8;
    localparam logic [3:0] ALU_SHL = 4'h9;

endpackage

// File: rtl/edulent_alu.sv
// Combinational ALU: operation chosen by the opcode high nibble.
module edulent_alu
    import edulent_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // One extra bit holds carry, borrow or the bit shifted out; logic ops leave it 0.
    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD: wide = {1'b0, x} + {1'b0, y};
            ALU_SUB: wide = {1'b0, x} - {1'b0, y};
            ALU_NOT: wide = {1'b0, ~x};
            ALU_AND: wide = {1'b0, x & y};
            ALU_OR:  wide = {1'b0, x | y};
            ALU_XOR: wide = {1'b0, x ^ y};
            ALU_SHL: wide = {x, 1'b0};
            default: wide = {1'b0, y};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];

endmodule

// File: rtl/edulent_datapath.sv
// EDULENT datapath: register file and transfers driven by the control unit.
module edulent_datapath
    import edulent_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PC_INIT = '0,
    parameter logic [DATA_W-1:0] SP_INIT = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_alu_calculate,
    input  logic              i_alu_res_to_ap,
    input  logic              i_reset_ir,
    output logic [DATA_W-1:0] o_opcode,
    output logic [DATA_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_in_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] pc, sp, ma, md, ir, a, ap, r;
    logic              flag_z, flag_c;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    transfer_cmd_t     cmd;
    logic              sel_ap;
    logic              branch_ok;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    // The AP destination is already implied by sel_ap, and the flags do not
    // depend on where the result lands, so this control bit carries no state.
    logic              unused_res_to_ap;
    assign unused_res_to_ap = i_alu_res_to_ap;

    // Accumulator select and branch condition decode from the current IR.
    always_comb begin
        cmd       = transfer_cmd_t'(i_transfer_cmd);
        sel_ap    = ir[1] | (ir == DATA_W'(OP_CALL));
        acc       = sel_ap ? ap : a;
        branch_ok = 1'b1;
        if (ir == DATA_W'(OP_JZ))
            branch_ok = flag_z;
        else if (ir == DATA_W'(OP_JC))
            branch_ok = flag_c;
    end

    edulent_alu #(.DATA_W(DATA_W)) u_alu (
        .x      (acc),
        .y      (md),
        .op     (ir[DATA_W-1 -: 4]),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // All architectural state; reset aborts any in-flight transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc        <= PC_INIT;
            sp        <= SP_INIT;
            ma        <= '0;
            md        <= '0;
            ir        <= '0;
            a         <= '0;
            ap        <= '0;
            r         <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (cmd == CMD_PC_MD && branch_ok)
                pc <= md;
            else if (cmd == CMD_PC_AP)
                pc <= ap;
            else if (i_inc_pc)
                pc <= pc + ONE;

            case (sp_op_t'(i_inc_dec_sp))
                SP_INC:  sp <= sp + ONE;
                SP_DEC:  sp <= sp - ONE;
                default: sp <= sp;
            endcase

            if (cmd == CMD_IR_MD)
                ir <= md;
            else if (i_reset_ir)
                ir <= '0;

            case (cmd)
                CMD_MA_PC:  ma <= pc;
                CMD_MD_MEM: md <= i_mem_rdata;
                CMD_MA_MD:  ma <= md;
                CMD_ACC_MD: if (sel_ap) ap <= md; else a <= md;
                CMD_MA_AP:  ma <= ap;
                CMD_MA_SP:  ma <= sp;
                CMD_MD_ACC: md <= acc;
                CMD_ACC_R:  if (sel_ap) ap <= r; else a <= r;
                CMD_A_IN:   a <= i_in_data;
                CMD_OUT_A:  out_data <= a;
                CMD_MD_PC:  md <= pc;
                default:    ;
            endcase

            out_valid <= (cmd == CMD_OUT_A);

            if (i_alu_calculate) begin
                r      <= alu_result;
                flag_z <= (alu_result == '0);
                flag_c <= alu_carry;
            end
        end
    end

    assign o_opcode    = ir;
    assign o_mem_addr  = ma;
    assign o_mem_wdata = md;
    assign o_mem_we    = (cmd == CMD_MEM_WR) & ~i_rst;
    assign o_out_data  = out_data;
    assign o_out_valid = out_valid;

endmodule

// File: tb/tb_edulent_datapath.sv
// Directed plus randomized bench for edulent_datapath against a transaction-level model.
module tb_edulent_datapath;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_transfer_cmd = 4'h0;
    logic       i_inc_pc = 1'b0;
    logic [1:0] i_inc_dec_sp = 2'b00;
    logic       i_alu_calculate = 1'b0;
    logic       i_alu_res_to_ap = 1'b0;
    logic       i_reset_ir = 1'b0;
    logic [7:0] o_opcode, o_mem_addr, o_mem_wdata, o_out_data;
    logic [7:0] i_mem_rdata;
    logic [7:0] i_in_data = 8'h00;
    logic       o_mem_we, o_out_valid;

    logic [7:0] tb_mem [0:255];
    logic [7:0] model_mem [0:255];

    logic [7:0] m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_r, m_out;
    logic       m_z, m_c, m_valid;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = tb_mem[o_mem_addr];

    edulent_datapath dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_transfer_cmd  (i_transfer_cmd),
        .i_inc_pc        (i_inc_pc),
        .i_inc_dec_sp    (i_inc_dec_sp),
        .i_alu_calculate (i_alu_calculate),
        .i_alu_res_to_ap (i_alu_res_to_ap),
        .i_reset_ir      (i_reset_ir),
        .o_opcode        (o_opcode),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rdata     (i_mem_rdata),
        .o_mem_we        (o_mem_we),
        .o_mem_wdata     (o_mem_wdata),
        .i_in_data       (i_in_data),
        .o_out_data      (o_out_data),
        .o_out_valid     (o_out_valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void alu_model(input int op, input int x, input int y,
                                      output int res, output bit cy);
        cy = 1'b0;
        case (op)
            3: begin res = (x + y) % 256; cy = (x + y) > 255; end
            4: begin res = (x - y + 256) % 256; cy = x < y; end
            5: res = 255 - x;
            6: res = x & y;
            7: res = x | y;
            8: res = x ^ y;
            9: begin res = (x * 2) % 256; cy = x >= 128; end
            default: res = y;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc = 8'h00; m_sp = 8'hFF; m_ma = 8'h00; m_md = 8'h00; m_ir = 8'h00;
        m_a = 8'h00; m_ap = 8'h00; m_r = 8'h00; m_out = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] c, input logic inc, input logic [1:0] spop,
                                       input logic calc, input logic rir, input logic [7:0] din);
        logic [7:0] n_pc, n_sp, n_ma, n_md, n_ir, n_a, n_ap, acc;
        bit sel, br, cy;
        int res;
        sel = m_ir[1] || (m_ir == 8'hC1);
        acc = sel ? m_ap : m_a;
        br  = (m_ir == 8'hA5) ? m_z : (m_ir == 8'hA9) ? m_c : 1'b1;
        alu_model(int'(m_ir[7:4]), int'(acc), int'(m_md), res, cy);
        n_pc = m_pc; n_sp = m_sp; n_ma = m_ma; n_md = m_md; n_ir = m_ir; n_a = m_a; n_ap = m_ap;
        if (c == 4'hB && br)   n_pc = m_md;
        else if (c == 4'hE)    n_pc = m_ap;
        else if (inc)          n_pc = m_pc + 8'd1;
        if (spop == 2'b01)      n_sp = m_sp + 8'd1;
        else if (spop == 2'b10) n_sp = m_sp - 8'd1;
        case (c)
            4'h1: n_ma = m_pc;
            4'h2: n_md = model_mem[m_ma];
            4'h3: n_ir = m_md;
            4'h4: n_ma = m_md;
            4'h5: if (sel) n_ap = m_md; else n_a = m_md;
            4'h6: n_ma = m_ap;
            4'h7: n_ma = m_sp;
            4'h8: n_md = acc;
            4'h9: model_mem[m_ma] = m_md;
            4'hA: if (sel) n_ap = m_r; else n_a = m_r;
            4'hC: n_a = din;
            4'hD: m_out = m_a;
            4'hF: n_md = m_pc;
            default: ;
        endcase
        if (rir && c != 4'h3) n_ir = 8'h00;
        m_valid = (c == 4'hD);
        if (calc) begin
            m_r = 8'(res);
            m_z = (res == 0);
            m_c = cy;
        end
        m_pc = n_pc; m_sp = n_sp; m_ma = n_ma; m_md = n_md; m_ir = n_ir; m_a = n_a; m_ap = n_ap;
    endfunction

    task automatic chk_ports();
        chk("opcode",    int'(o_opcode),    int'(m_ir));
        chk("mem_addr",  int'(o_mem_addr),  int'(m_ma));
        chk("mem_wdata", int'(o_mem_wdata), int'(m_md));
        chk("out_data",  int'(o_out_data),  int'(m_out));
        chk("out_valid", int'(o_out_valid), int'(m_valid));
    endtask

    task automatic step(input logic [3:0] c, input logic inc, input logic [1:0] spop,
                        input logic calc, input logic rir, input logic [7:0] din);
        logic       we_s;
        logic [7:0] a_s, d_s;
        i_transfer_cmd  = c;
        i_inc_pc        = inc;
        i_inc_dec_sp    = spop;
        i_alu_calculate = calc;
        i_alu_res_to_ap = 1'($urandom_range(0, 1));
        i_reset_ir      = rir;
        i_in_data       = din;
        @(negedge i_clk);
        chk("mem_we", int'(o_mem_we), (c == 4'h9) ? 1 : 0);
        we_s = o_mem_we; a_s = o_mem_addr; d_s = o_mem_wdata;
        @(posedge i_clk);
        if (we_s) tb_mem[a_s] = d_s;
        model_step(c, inc, spop, calc, rir, din);
        #1;
        if (c == 4'h9) chk("mem_write", int'(tb_mem[a_s]), int'(model_mem[a_s]));
        chk_ports();
    endtask

    task automatic tx(input logic [3:0] c);
        step(c, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] val);
        tb_mem[addr] = val;
        model_mem[addr] = val;
    endtask

    task automatic load_md(input logic [7:0] v);
        poke(m_pc, v);
        tx(4'h1);
        step(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic fetch_ir(input logic [7:0] v);
        load_md(v);
        tx(4'h3);
    endtask

    task automatic do_reset();
        i_transfer_cmd = 4'h0; i_inc_pc = 1'b0; i_inc_dec_sp = 2'b00;
        i_alu_calculate = 1'b0; i_reset_ir = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_opcode", int'(o_opcode), 0);
        chk("rst_addr",   int'(o_mem_addr), 0);
        chk("rst_wdata",  int'(o_mem_wdata), 0);
        chk("rst_out",    int'(o_out_data), 0);
        chk("rst_valid",  int'(o_out_valid), 0);
        chk("rst_we",     int'(o_mem_we), 0);
        i_rst = 1'b0;

        // fetch
        poke(8'h00, 8'h19);
        tx(4'h1);
        chk("fetch_ma", int'(o_mem_addr), 8'h00);
        step(4'h2, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        chk("fetch_md", int'(o_mem_wdata), 8'h19);
        tx(4'h3);
        chk("fetch_ir", int'(o_opcode), 8'h19);
        tx(4'hF);
        chk("fetch_pc", int'(o_mem_wdata), 8'h01);

        // AP loads
        fetch_ir(8'h1B);
        load_md(8'h40);
        tx(4'h5); tx(4'h6);
        chk("ap_load", int'(o_mem_addr), 8'h40);
        fetch_ir(8'h10);
        tx(4'h8);
        chk("a_unchanged", int'(o_mem_wdata), 8'h00);
        fetch_ir(8'hC1);
        load_md(8'h77);
        tx(4'h5); tx(4'h6);
        chk("call_ap", int'(o_mem_addr), 8'h77);

        // add, then flag-driven jumps
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 8'hF0);
        fetch_ir(8'h39);
        load_md(8'h20);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00);
        tx(4'hA); tx(4'h8);
        chk("add_res", int'(o_mem_wdata), 8'h10);
        fetch_ir(8'hA9);
        load_md(8'h80);
        tx(4'hB); tx(4'hF);
        chk("jc_taken", int'(o_mem_wdata), 8'h80);
        fetch_ir(8'hA5);
        load_md(8'h33);
        tx(4'hB); tx(4'hF);
        chk("jz_not_taken", int'(o_mem_wdata), 8'h82);

        // subtract to zero
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 8'hF0);
        fetch_ir(8'h49);
        load_md(8'hF0);
        step(4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00);
        tx(4'hA); tx(4'h8);
        chk("sub_res", int'(o_mem_wdata), 8'h00);
        fetch_ir(8'hA5);
        load_md(8'h20);
        tx(4'hB); tx(4'hF);
        chk("jz_taken", int'(o_mem_wdata), 8'h20);
        fetch_ir(8'hA9);
        load_md(8'h44);
        tx(4'hB); tx(4'hF);
        chk("jc_not_taken", int'(o_mem_wdata), 8'h22);
        fetch_ir(8'hA1);
        load_md(8'h60);
        tx(4'hB); tx(4'hF);
        chk("jmp_uncond", int'(o_mem_wdata), 8'h60);
        step(4'hF, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        chk("md_pc_preinc", int'(o_mem_wdata), 8'h60);
        tx(4'hF);
        chk("pc_inc", int'(o_mem_wdata), 8'h61);
        step(4'h3, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
        chk("ir_load_wins", int'(o_opcode), 8'h61);
        step(4'h0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00);
        chk("ir_clear", int'(o_opcode), 8'h00);

        // stack and memory write
        do_reset();
        step(4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        tx(4'h7);
        chk("sp_dec", int'(o_mem_addr), 8'hFE);
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A);
        tx(4'h8);
        chk("push_md", int'(o_mem_wdata), 8'h5A);
        tx(4'h9);
        chk("push_mem", int'(tb_mem[8'hFE]), 8'h5A);
        chk("push_addr", int'(o_mem_addr), 8'hFE);
        tx(4'h0);
        step(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        step(4'h0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        tx(4'h7);
        chk("sp_wrap", int'(o_mem_addr), 8'h00);

        // IO
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 8'h3C);
        tx(4'hD);
        chk("out_data", int'(o_out_data), 8'h3C);
        chk("out_pulse", int'(o_out_valid), 1);
        tx(4'h0);
        chk("out_pulse_end", int'(o_out_valid), 0);

        // reset during a write
        step(4'hC, 1'b0, 2'b00, 1'b0, 1'b0, 8'hAB);
        tx(4'h8);
        poke(8'h00, 8'h19);
        i_transfer_cmd = 4'h9;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_blocks_we", int'(o_mem_we), 0);
        if (o_mem_we) tb_mem[o_mem_addr] = o_mem_wdata;
        @(posedge i_clk);
        #1;
        chk("rst_mem_kept", int'(tb_mem[8'h00]), 8'h19);
        chk("rst2_wdata", int'(o_mem_wdata), 0);
        chk("rst2_out", int'(o_out_data), 0);
        i_transfer_cmd = 4'h0;
        i_rst = 1'b0;
        model_reset();
        tx(4'hF);
        chk("rst2_pc", int'(o_mem_wdata), 8'h00);
        tx(4'h7);
        chk("rst2_sp", int'(o_mem_addr), 8'hFF);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
